simon_iterative_decipher_core: RTL and testbench
================================================

Name: simon_iterative_decipher_core

Overview:
- Iterative SIMON32/64 decryption core, the inverse of the encryption core.
- Accepts a 32-bit ciphertext and a 64-bit key through a valid/ready handshake and runs the key schedule forward to recover round keys k31..k28.
- Then runs 32 inverse rounds, regenerating round keys backwards on the fly with no round-key RAM.
- Optional last-key cache skips expansion when the same key is reused.

Parameters:
- ROUNDS, 32, number of rounds. Fixed for SIMON32/64; any other value is unsupported.
- KEY_CACHE_EN, 1, when 1, instantiates the cached k31..k28 window and honours key_reuse.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  ciphertext/key offered
- in_ready  out  1  core idle, can accept
- ciphertext  in  32  block; x = [31:16], y = [15:0]
- key  in  64  k0 = [15:0], k1 = [31:16], k2 = [47:32], k3 = [63:48]
- key_reuse  in  1  sampled with the input; use the cached schedule if valid
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- plaintext  out  32  result; x = [31:16], y = [15:0]
- busy  out  1  high in EXPAND or DECRYPT

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst forces state=IDLE, all registers 0 and cache_valid=0.
  - Outputs during reset: out_valid=0, plaintext=0, busy=0, in_ready=1.
  - Reset mid-operation aborts the operation and discards the result.
- Definitions:
  - f(v) = (rol1(v) & rol8(v)) ^ rol2(v).
  - c = 16'hFFFC.
  - z0 = 62-bit sequence 11111010001001010110000111001101111101000100101011000011100110; element i is the i-th bit from the left, i = 0..61.
- Key window W[63:0]: four 16-bit words, lowest index at [15:0].
- Forward step, k_{j+4} = c ^ z0[j] ^ k_j ^ t ^ ror1(t), with t = ror3(k_{j+3}) ^ k_{j+1}.
  - W <= {k_{j+4}, W[63:16]}.
- Inverse step at round i, k_{i-4} = k_i ^ c ^ z0[i-4] ^ t ^ ror1(t), with t = ror3(k_{i-1}) ^ k_{i-3}.
  - W <= {W[47:0], k_{i-4}}.
  - For i<4, the shifted-in word is 0.
- Inverse round with key k = W[63:48]:
  - x_new = y.
  - y_new = x ^ f(y) ^ k.
- FSM:
  - IDLE: in_ready=1. On in_valid:
    - load S <= ciphertext;
    - if KEY_CACHE_EN & key_reuse & cache_valid: W <= cache, rnd <= 31, go to DECRYPT;
    - else: W <= key, j <= 0, go to EXPAND.
  - EXPAND: one forward step per cycle, j = 0..27.
    - On the j=27 step, W holds {k31,k30,k29,k28}.
    - The same edge writes cache <= next W and sets cache_valid=1, then sets rnd <= 31 and goes to DECRYPT.
  - DECRYPT: one inverse round plus one inverse key step per cycle, rnd 31 down to 0.
    - On the rnd=0 edge, plaintext <= S_next, out_valid <= 1, go to DONE.
  - DONE: out_valid=1 and plaintext held stable.
    - On out_ready: out_valid <= 0, go to IDLE.
- Latency, from the accepting edge to out_valid high: 60 edges with expansion, 32 edges with a cache hit.
- in_ready=0 outside IDLE. in_valid/data presented while busy or in DONE are ignored; no queueing.
- key_reuse=1 with cache_valid=0 falls back to full expansion. With KEY_CACHE_EN=0, key_reuse is ignored.
- The cache is not compared against the key port; key_reuse is a caller assertion.
- plaintext changes only on the DONE entry edge and at reset.

Decomposition:
- simon_pkg:
  - constants Z0 (62-bit), C_CONST, ROUNDS, KEY_EXP_STEPS=28;
  - state_t enum {IDLE, EXPAND, DECRYPT, DONE};
  - functions f_simon(), ror16(), rol16().
- Sub-module simon_key_step (combinational): inputs W and z bit plus a direction bit; output the next W, forward or inverse.
  - Shareable with a future re-keyed encryption core.
- Inverse round is inline logic; a separate module adds nothing.

Test Plan:
- Reset, then ciphertext=32'hC69BE9BB, key=64'h1918111009080100, key_reuse=0, out_ready=1 -> out_valid 60 edges after accept, plaintext=32'h65656877, back to IDLE.
- Immediately repeat with key_reuse=1 -> out_valid after 32 edges, plaintext=32'h65656877.
- After a fresh reset, key_reuse=1 with the same vector -> cache invalid, 60-edge latency, correct plaintext.
- Hold out_ready=0 for 10 cycles after out_valid, and toggle in_valid with other data -> plaintext stays 32'h65656877, in_ready=0, no new accept; release -> IDLE.
- Assert rst at DECRYPT rnd=15 -> out_valid=0, plaintext=0, busy=0, in_ready=1 asynchronously; a new vector with key_reuse=1 takes 60 edges (cache invalidated) and decrypts correctly.
- Round-trip: 1000 random key/plaintext pairs encrypted by the encryption core, ciphertext fed here with random key_reuse/out_ready -> plaintext matches every time.

Source files
------------

// File: rtl/simon_iterative_decipher_core_pkg.sv
// SIMON32/64 shared constants, FSM state type and word helpers.
// Used by the decipher core and its key-schedule step.
package simon_pkg;

    localparam int          ROUNDS        = 32;
    localparam int          KEY_EXP_STEPS = 28;
    localparam logic [15:0] C_CONST       = 16'hFFFC;
    // Bit j of the z0 sequence is Z0[61-j] (leftmost digit is j=0).
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DECRYPT,
        DONE
    } state_t;

    function automatic logic [15:0] rol16(
        input logic [15:0] v,
        input logic [3:0]  n
    );
        logic [31:0] w;
        w = {v, v} << n;
        return w[31:16];
    endfunction

    function automatic logic [15:0] ror16(
        input logic [15:0] v,
        input logic [3:0]  n
    );
        logic [31:0] w;
        w = {v, v} >> n;
        return w[15:0];
    endfunction

    function automatic logic [15:0] f_simon(input logic [15:0] v);
        return (rol16(v, 4'd1) & rol16(v, 4'd8)) ^ rol16(v, 4'd2);
    endfunction

    function automatic logic z0_bit(input logic [5:0] idx);
        logic [5:0] pos;
        pos = 6'd61 - idx;
        return (idx < 6'd62) ? Z0[pos] : 1'b0;
    endfunction

endpackage

// File: rtl/simon_iterative_decipher_core_if.sv
// Handshake bundle of the SIMON32/64 decipher core.
// master: request/response side; slave: the core.
interface simon_iterative_decipher_core_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] ciphertext;
    logic [63:0] key;
    logic        key_reuse;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] plaintext;
    logic        busy;

    modport master (
        output in_valid, ciphertext, key, key_reuse, out_ready,
        input  in_ready, out_valid, plaintext, busy
    );

    modport slave (
        input  in_valid, ciphertext, key, key_reuse, out_ready,
        output in_ready, out_valid, plaintext, busy
    );

endinterface

// File: rtl/simon_iterative_decipher_core_key_step.sv
// One SIMON32/64 key-schedule step over a 4-word window.
// Ports: i_w window, i_z z0 bit, i_dir (0 fwd, 1 inv), o_w next window.
module simon_key_step (
    input  logic [63:0] i_w,
    input  logic        i_z,
    input  logic        i_dir,
    output logic [63:0] o_w
);
    import simon_pkg::*;

    logic [15:0] w_tf;
    logic [15:0] w_ti;
    logic [15:0] w_kf;
    logic [15:0] w_ki;

    // Forward: W = {k(j+3),k(j+2),k(j+1),k(j)} -> new top word.
    assign w_tf = ror16(i_w[63:48], 4'd3) ^ i_w[31:16];
    assign w_kf = C_CONST ^ {15'd0, i_z} ^ i_w[15:0]
                ^ w_tf ^ ror16(w_tf, 4'd1);

    // Inverse: W = {k(i),k(i-1),k(i-2),k(i-3)} -> new bottom word.
    assign w_ti = ror16(i_w[47:32], 4'd3) ^ i_w[15:0];
    assign w_ki = C_CONST ^ {15'd0, i_z} ^ i_w[63:48]
                ^ w_ti ^ ror16(w_ti, 4'd1);

    assign o_w = i_dir ? {i_w[47:0], w_ki} : {w_kf, i_w[63:16]};

endmodule

// File: rtl/simon_iterative_decipher_core.sv
// Iterative SIMON32/64 decryption: forward key expansion, then 32
// inverse rounds with backward key regeneration. clk, rst (async low), bus.
module simon_iterative_decipher_core
    import simon_pkg::*;
#(
    parameter int ROUNDS       = 32,
    parameter bit KEY_CACHE_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    simon_iterative_decipher_core_if.slave bus
);

    localparam logic [4:0] LAST_RND  = 5'(ROUNDS - 1);
    localparam logic [4:0] LAST_STEP = 5'(KEY_EXP_STEPS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_s;
    logic [31:0] r_pt;
    logic [63:0] r_w;
    logic [63:0] r_cache;
    logic        r_cache_v;
    logic [4:0]  r_cnt;
    logic        r_out_valid;

    logic        w_hit;
    logic        w_dir;
    logic        w_exp_last;
    logic [5:0]  w_zidx;
    logic [63:0] w_w_step;
    logic [63:0] w_w_next;
    logic [31:0] w_s_next;

    assign w_hit      = KEY_CACHE_EN && bus.key_reuse && r_cache_v;
    assign w_dir      = (r_state == DECRYPT);
    assign w_exp_last = (r_state == EXPAND) && (r_cnt == LAST_STEP);

    // Expansion step j uses z0[j]; inverse step at round i uses z0[i-4].
    assign w_zidx = w_dir ? (6'(r_cnt) - 6'd4) : 6'(r_cnt);

    simon_key_step u_key_step (
        .i_w   (r_w),
        .i_z   (z0_bit(w_zidx)),
        .i_dir (w_dir),
        .o_w   (w_w_step)
    );

    // Rounds 3..0 have no earlier key to regenerate.
    assign w_w_next = (w_dir && r_cnt < 5'd4) ? {r_w[47:0], 16'd0}
                                              : w_w_step;

    assign w_s_next = {r_s[15:0],
                       r_s[31:16] ^ f_simon(r_s[15:0]) ^ r_w[63:48]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid) w_next_state = w_hit ? DECRYPT : EXPAND;
            EXPAND:  if (w_exp_last) w_next_state = DECRYPT;
            DECRYPT: if (r_cnt == 5'd0) w_next_state = DONE;
            DONE:    if (bus.out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s         <= '0;
            r_w         <= '0;
            r_cnt       <= '0;
            r_pt        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_s <= bus.ciphertext;
                        if (w_hit) begin
                            r_w   <= r_cache;
                            r_cnt <= LAST_RND;
                        end else begin
                            r_w   <= bus.key;
                            r_cnt <= 5'd0;
                        end
                    end
                end
                EXPAND: begin
                    r_w   <= w_w_next;
                    r_cnt <= w_exp_last ? LAST_RND : r_cnt + 5'd1;
                end
                DECRYPT: begin
                    r_s   <= w_s_next;
                    r_w   <= w_w_next;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_pt        <= w_s_next;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    generate
        if (KEY_CACHE_EN) begin : g_cache
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cache   <= '0;
                    r_cache_v <= 1'b0;
                end else if (w_exp_last) begin
                    r_cache   <= w_w_next;
                    r_cache_v <= 1'b1;
                end
            end
        end else begin : g_no_cache
            assign r_cache   = '0;
            assign r_cache_v = 1'b0;
        end
    endgenerate

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state == EXPAND) || (r_state == DECRYPT);
    assign bus.out_valid = r_out_valid;
    assign bus.plaintext = r_pt;

endmodule

// File: tb/tb_simon_iterative_decipher_core.sv
// Bench for the SIMON32/64 decipher core: vector table, corner
// sequences and random round-trips against a reference encryptor.
module tb_simon_iterative_decipher_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    simon_iterative_decipher_core_if bus ();

    simon_iterative_decipher_core #(
        .ROUNDS       (32),
        .KEY_CACHE_EN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] sb_q[$];

    localparam logic [63:0] KEY_A = 64'h1918111009080100;
    localparam logic [31:0] CT_A  = 32'hC69BE9BB;
    localparam logic [31:0] PT_A  = 32'h65656877;

    typedef struct {
        logic [31:0] ct;
        logic [63:0] key;
        logic        ru;
        logic [31:0] pt;
        int          lat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rl(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
        return r;
    endfunction

    // Reference SIMON32/64 encryption with a full round-key array.
    function automatic logic [31:0] enc(input logic [31:0] pt,
                                        input logic [63:0] key);
        logic [15:0] k[32];
        logic [15:0] x, y, t;
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = {k[i-1][2:0], k[i-1][15:3]};
            t = t ^ k[i-3];
            t = t ^ {t[0], t[15:1]};
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    // Scoreboard: one result per output handshake.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 64'(bus.plaintext), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("sb_plaintext", 64'(bus.plaintext), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [31:0] ct, input logic [63:0] key,
                        input logic ru, input logic [31:0] exp,
                        input int exp_lat, input bit rnd_rdy);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
        bus.ciphertext = ct;
        bus.key        = key;
        bus.key_reuse  = ru;
        bus.in_valid   = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        n = 0;
        while (bus.out_valid && n < 100) begin
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] key;
        logic [63:0] prev;
        logic [31:0] pt;
        logic        ru;
        int          n;

        tbl[0] = '{CT_A, KEY_A, 1'b0, PT_A, 60};
        tbl[1] = '{CT_A, KEY_A, 1'b1, PT_A, 32};
        tbl[2] = '{enc(32'h0, 64'h0), 64'h0, 1'b0, 32'h0, 60};
        tbl[3] = '{enc(32'hFFFFFFFF, '1), '1, 1'b0, 32'hFFFFFFFF, 60};
        tbl[4] = '{enc(32'h12345678, '1), '1, 1'b1, 32'h12345678, 32};
        tbl[5] = '{enc(32'hDEADBEEF, 64'h0F1E2D3C4B5A6978),
                   64'h0F1E2D3C4B5A6978, 1'b0, 32'hDEADBEEF, 60};
        tbl[6] = '{enc(32'hA5A55A5A, 64'h0F1E2D3C4B5A6978),
                   64'h0F1E2D3C4B5A6978, 1'b1, 32'hA5A55A5A, 32};

        bus.in_valid   = 1'b0;
        bus.ciphertext = '0;
        bus.key        = '0;
        bus.key_reuse  = 1'b0;
        bus.out_ready  = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_plaintext", 64'(bus.plaintext), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].ct, tbl[i].key, tbl[i].ru, tbl[i].pt, tbl[i].lat, 1'b0);
            chk("idle_after", 64'(bus.in_ready), 64'd1);
        end

        // Fresh reset: cache invalid, key_reuse falls back to expansion.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        send(CT_A, KEY_A, 1'b1, PT_A, 60, 1'b0);

        // Stall in DONE while other requests are offered.
        bus.out_ready = 1'b0;
        bus.ciphertext = CT_A;
        bus.key        = KEY_A;
        bus.key_reuse  = 1'b1;
        bus.in_valid   = 1'b1;
        sb_q.push_back(PT_A);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_latency", 64'(n), 64'd32);
        for (int c = 0; c < 10; c++) begin
            bus.in_valid   = (c % 2 == 0);
            bus.ciphertext = $urandom;
            bus.key        = {$urandom, $urandom};
            bus.key_reuse  = 1'b0;
            @(posedge clk); #1;
            chk("hold_plaintext", 64'(bus.plaintext), 64'(PT_A));
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rel_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rel_busy", 64'(bus.busy), 64'd0);

        // Abort by reset at DECRYPT round 15.
        bus.ciphertext = CT_A;
        bus.key        = KEY_A;
        bus.key_reuse  = 1'b0;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        chk("mid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_plaintext", 64'(bus.plaintext), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send(CT_A, KEY_A, 1'b1, PT_A, 60, 1'b0);

        // Random round-trips; reuse only repeats the cached key.
        prev = KEY_A;
        for (int i = 0; i < 1000; i++) begin
            ru = (i > 0) && ($urandom_range(0, 1) == 1);
            key = ru ? prev : {$urandom, $urandom};
            pt = $urandom;
            bus.out_ready = 1'($urandom_range(0, 1));
            send(enc(pt, key), key, ru, pt, ru ? 32 : 60, 1'b1);
            prev = key;
        end

        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
